// File: rtl/gpu_pkg.sv
// Shared types and default widths for the VRAM arbitration slice.
package gpu_pkg;

  localparam int unsigned VRAM_ADDR_W = 14;
  localparam int unsigned VRAM_DATA_W = 64;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RND  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic {
    S_RENDER    = 1'b0,
    S_CPU_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vram_rdata_router.sv
// Two-stage read-return pipe: owner tag on grant, then registered data/valid steering.
module vram_rdata_router
  import gpu_pkg::*;
#(
  parameter int unsigned DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  owner_e            grant_owner,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rnd_rvalid,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_rdata
);

  owner_e owner_q;

  // Reset drops the in-flight tag so a late memory return never surfaces.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      o_rnd_rvalid <= 1'b0;
      o_cpu_rvalid <= 1'b0;
      o_rdata      <= '0;
    end else begin
      owner_q      <= grant_owner;
      o_rnd_rvalid <= (owner_q == OWN_RND);
      o_cpu_rvalid <= (owner_q == OWN_CPU);
      if (owner_q != OWN_NONE) o_rdata <= i_mem_rdata;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Render/CPU arbiter for a single-port VRAM: render priority, CPU starvation relief, vblank and locked bursts.
module vram_port_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W       = VRAM_ADDR_W,
  parameter int unsigned DATA_W       = VRAM_DATA_W,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned BURST_MAX    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_vblank,
  input  logic              i_rnd_req,
  input  logic [ADDR_W-1:0] i_rnd_addr,
  output logic              o_rnd_gnt,
  output logic              o_rnd_rvalid,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_cpu_lock,
  output logic              o_cpu_gnt,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BURST_W  = $clog2(BURST_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(STARVE_LIMIT);
  localparam logic [BURST_W-1:0]  BURST_END  = BURST_W'(BURST_MAX);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                cpu_force;
  owner_e              grant_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RENDER;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    starve_d  = '0;
    o_rnd_gnt = 1'b0;
    o_cpu_gnt = 1'b0;
    cpu_force = i_vblank | (starve_q == STARVE_SAT);

    unique case (state_q)
      S_RENDER: begin
        if (i_cpu_req && (cpu_force || !i_rnd_req)) begin
          o_cpu_gnt = 1'b1;
          // A one-deep burst limit would end on its first grant, so no burst state then.
          if (i_cpu_lock && (BURST_MAX > 1)) begin
            state_d = S_CPU_BURST;
            burst_d = BURST_W'(1);
          end
        end else if (i_rnd_req) begin
          o_rnd_gnt = 1'b1;
        end
      end
      S_CPU_BURST: begin
        if (i_cpu_req) begin
          o_cpu_gnt = 1'b1;
          burst_d   = burst_q + 1'b1;
          if (!i_cpu_lock || (burst_d == BURST_END)) begin
            state_d = S_RENDER;
            burst_d = '0;
          end
        end else begin
          state_d = S_RENDER;
          burst_d = '0;
        end
      end
      default: begin
        state_d = S_RENDER;
        burst_d = '0;
      end
    endcase

    if (reset) begin
      o_rnd_gnt = 1'b0;
      o_cpu_gnt = 1'b0;
    end

    if (i_cpu_req && !o_cpu_gnt)
      starve_d = (starve_q == STARVE_SAT) ? starve_q : starve_q + 1'b1;
  end

  always_comb begin
    o_mem_en    = o_rnd_gnt | o_cpu_gnt;
    o_mem_we    = o_cpu_gnt & i_cpu_we;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    grant_owner = OWN_NONE;
    if (o_cpu_gnt) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      grant_owner = i_cpu_we ? OWN_NONE : OWN_CPU;
    end else if (o_rnd_gnt) begin
      o_mem_addr  = i_rnd_addr;
      grant_owner = OWN_RND;
    end
  end

  vram_rdata_router #(
    .DATA_W (DATA_W)
  ) u_rdata_router (
    .clk          (clk),
    .reset        (reset),
    .grant_owner  (grant_owner),
    .i_mem_rdata  (i_mem_rdata),
    .o_rnd_rvalid (o_rnd_rvalid),
    .o_cpu_rvalid (o_cpu_rvalid),
    .o_rdata      (o_rdata)
  );

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomized + directed bench for vram_port_arbiter against a cycle-level behavioural model.
module tb_vram_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 64;
  localparam int SL = 8;
  localparam int BM = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_vblank = 1'b0, i_rnd_req = 1'b0, i_cpu_req = 1'b0, i_cpu_we = 1'b0, i_cpu_lock = 1'b0;
  logic [AW-1:0] i_rnd_addr = '0, i_cpu_addr = '0;
  logic [DW-1:0] i_cpu_wdata = '0;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          o_rnd_gnt, o_rnd_rvalid, o_cpu_gnt, o_cpu_rvalid, o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_rdata, o_mem_wdata;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .STARVE_LIMIT (SL), .BURST_MAX (BM)
  ) dut (
    .clk (clk), .reset (reset), .i_vblank (i_vblank),
    .i_rnd_req (i_rnd_req), .i_rnd_addr (i_rnd_addr), .o_rnd_gnt (o_rnd_gnt), .o_rnd_rvalid (o_rnd_rvalid),
    .i_cpu_req (i_cpu_req), .i_cpu_we (i_cpu_we), .i_cpu_addr (i_cpu_addr), .i_cpu_wdata (i_cpu_wdata),
    .i_cpu_lock (i_cpu_lock), .o_cpu_gnt (o_cpu_gnt), .o_cpu_rvalid (o_cpu_rvalid), .o_rdata (o_rdata),
    .o_mem_en (o_mem_en), .o_mem_we (o_mem_we), .o_mem_addr (o_mem_addr), .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  // Memory macro seen by the DUT, and an independent copy used for predictions.
  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata     <= mem[o_mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int a);
    return {32'hC0DE_0000 | 32'(a), ~32'(a) ^ 32'h5A5A_5A5A};
  endfunction

  // Model state: denied-cycle count, burst bookkeeping, read-return schedule.
  int          denied = 0, blen = 0;
  bit          in_burst = 0;
  int          p1_own = 0, p2_own = 0;
  logic [63:0] p1_data = '0, exp_rdata = '0;

  bit          obs_rnd, obs_cpu, obs_we, obs_rrv, obs_crv;
  logic [63:0] obs_rdata;

  task automatic step(input bit rst, input bit vb, input bit rr, input logic [AW-1:0] ra,
                      input bit cr, input bit cw, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd, input bit cl);
    bit w_cpu, w_rnd;
    reset = rst; i_vblank = vb; i_rnd_req = rr; i_rnd_addr = ra;
    i_cpu_req = cr; i_cpu_we = cw; i_cpu_addr = ca; i_cpu_wdata = cd; i_cpu_lock = cl;
    #1;
    obs_rnd = o_rnd_gnt; obs_cpu = o_cpu_gnt; obs_we = o_mem_we;
    obs_rrv = o_rnd_rvalid; obs_crv = o_cpu_rvalid; obs_rdata = o_rdata;

    w_cpu = !rst && cr && (in_burst || vb || denied == SL || !rr);
    w_rnd = !rst && !in_burst && rr && !w_cpu;

    check("rnd_gnt", o_rnd_gnt, w_rnd);
    check("cpu_gnt", o_cpu_gnt, w_cpu);
    check("mem_en", o_mem_en, w_cpu || w_rnd);
    check("mem_we", o_mem_we, w_cpu && cw);
    check("mem_addr", o_mem_addr, w_cpu ? ca : (w_rnd ? ra : '0));
    check("mem_wdata", o_mem_wdata, w_cpu ? cd : '0);
    check("rnd_rvalid", o_rnd_rvalid, p2_own == 1);
    check("cpu_rvalid", o_cpu_rvalid, p2_own == 2);
    check("rdata", o_rdata, exp_rdata);

    if (rst) begin
      denied = 0; in_burst = 0; blen = 0; p1_own = 0; p2_own = 0; exp_rdata = '0;
    end else begin
      p2_own = p1_own;
      if (p1_own != 0) exp_rdata = p1_data;
      p1_own  = w_cpu ? (cw ? 0 : 2) : (w_rnd ? 1 : 0);
      p1_data = ref_mem[w_cpu ? ca : ra];
      if (w_cpu && cw) ref_mem[ca] = cd;
      denied = (cr && !w_cpu) ? ((denied < SL) ? denied + 1 : SL) : 0;
      if (w_cpu) begin
        if (!in_burst) begin
          if (cl && BM > 1) begin in_burst = 1; blen = 1; end
        end else begin
          blen++;
          if (!cl || blen == BM) begin in_burst = 0; blen = 0; end
        end
      end else if (in_burst) begin
        in_burst = 0; blen = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = pat(a);
      ref_mem[a] = pat(a);
    end
    mem[14'h3FFF] = 64'hDEAD_BEEF_0123_4567;
    ref_mem[14'h3FFF] = 64'hDEAD_BEEF_0123_4567;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    step(0, 0, 0, '0, 0, 0, '0, '0, 0);
    check("reset_rdata", obs_rdata, '0);
    check("reset_rvalid", {obs_rrv, obs_crv}, 2'b00);

    // Render-only stream 0x10..0x14.
    for (int i = 0; i < 8; i++) begin
      step(0, 0, i < 5, AW'(16 + i), 0, 0, '0, '0, 0);
      check("ro_rnd_gnt", obs_rnd, i < 5);
      check("ro_rnd_rvalid", obs_rrv, (i >= 2) && (i <= 6));
      check("ro_cpu", {obs_cpu, obs_crv}, 2'b00);
      if ((i >= 2) && (i <= 6)) check("ro_rdata", obs_rdata, pat(16 + i - 2));
    end

    // Both requesting outside blanking: 8 render grants, then one forced CPU grant.
    for (int i = 0; i < 27; i++) begin
      step(0, 0, 1, AW'(i), 1, 0, AW'(100 + i), '0, 0);
      check("ratio_cpu", obs_cpu, (i % 9) == 8);
      check("ratio_rnd", obs_rnd, (i % 9) != 8);
    end
    idle(3);

    // Blanking: CPU every cycle.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, AW'(i), 1, 0, AW'(200 + i), '0, 0);
      check("vb_cpu", obs_cpu, 1);
      check("vb_rnd", obs_rnd, 0);
    end
    idle(3);

    // Locked CPU write burst of six against a busy renderer.
    begin
      int ngr;
      ngr = 0;
      for (int i = 0; i < 23; i++) begin
        bit req;
        req = ngr < 6;
        step(0, 0, 1, AW'(40 + i), req, 1, AW'(i), 64'hB000_0000 + 64'(i), 1);
        if (obs_cpu) ngr++;
        check("burst_cpu", obs_cpu, ((i >= 8) && (i <= 11)) || (i == 20) || (i == 21));
        check("burst_we", obs_we, ((i >= 8) && (i <= 11)) || (i == 20) || (i == 21));
        check("burst_rnd", obs_rnd, (i < 8) || ((i >= 12) && (i <= 19)));
      end
    end
    idle(3);

    // CPU read at the top address.
    step(0, 0, 0, '0, 1, 0, 14'h3FFF, '0, 0);
    check("cpurd_gnt", obs_cpu, 1);
    step(0, 0, 0, '0, 0, 0, '0, '0, 0);
    check("cpurd_early", obs_crv, 0);
    step(0, 0, 0, '0, 0, 0, '0, '0, 0);
    check("cpurd_rvalid", obs_crv, 1);
    check("cpurd_rnd_rvalid", obs_rrv, 0);
    check("cpurd_data", obs_rdata, 64'hDEAD_BEEF_0123_4567);
    step(0, 0, 0, '0, 0, 0, '0, '0, 0);
    check("cpurd_pulse", obs_crv, 0);

    // Reset one cycle after a render grant, with the CPU partly starved.
    for (int i = 0; i < 5; i++) step(0, 0, 1, AW'(i), 1, 0, '0, '0, 0);
    step(1, 0, 0, '0, 0, 0, '0, '0, 0);
    step(0, 0, 0, '0, 0, 0, '0, '0, 0);
    check("rst_gnt", {obs_rnd, obs_cpu, obs_we}, 3'b000);
    check("rst_rvalid", {obs_rrv, obs_crv}, 2'b00);
    check("rst_rdata", obs_rdata, '0);
    step(0, 0, 0, '0, 0, 0, '0, '0, 0);
    check("rst_late_rvalid", {obs_rrv, obs_crv}, 2'b00);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, AW'(i), 1, 0, '0, '0, 0);
      check("rst_starve", obs_cpu, i == 8);
    end
    idle(2);

    // Random traffic against the model.
    begin
      bit vb;
      vb = 0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 15) == 0) vb = !vb;
        step($urandom_range(0, 63) == 0, vb, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)),
             $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)),
             {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
